seg_disp_sched: RTL and testbench

- AHB-Lite master that schedules display updates for the 8-digit seg7x8 AHB slave.
- Two hardware requesters (req0, req1) each offer a 32-bit hex value plus 8 decimal-point bits.
- Round-robin arbitration picks one request. The block formats it into two word writes to the display slave: word 0 at BASE_ADDR+0x0 (digits 0-3), word 1 at BASE_ADDR+0x4 (digits 4-7).
- Sits between status/debug logic and the AHB interconnect, in place of CPU pokes to the display.

---
 rtl/seg_disp_pkg.sv | 30 +++
 rtl/seg_disp_sched_if.sv | 22 ++
 rtl/seg_rr_arb2.sv | 18 +
 rtl/seg_disp_sched.sv | 169 ++++++++++++++++
 tb/tb_seg_disp_sched.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared types, bus constants and digit packing for seg_disp_sched
package seg_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_A0   = 2'd1,
        ST_A1D0 = 2'd2,
        ST_D1   = 2'd3
    } state_t;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;
    localparam logic [31:0] WORD0_OFS     = 32'h0000_0000;
    localparam logic [31:0] WORD1_OFS     = 32'h0000_0004;

    function automatic logic [7:0] digit_byte(input logic [3:0] value, input logic dp);
        return {3'b000, dp, value};
    endfunction

    // Four digits (16 value bits, 4 dp bits) into one display word, digit 0 in the low byte.
    function automatic logic [31:0] pack_word(input logic [15:0] values, input logic [3:0] dps);
        logic [31:0] word;
        for (int k = 0; k < 4; k++) begin
            word[8*k +: 8] = digit_byte(values[4*k +: 4], dps[k]);
        end
        return word;
    endfunction

endpackage

// File: rtl/seg_disp_sched_if.sv
// rtl/seg_disp_sched_if.sv - AHB-Lite write-path bundle between seg_disp_sched and the interconnect
interface seg_disp_sched_if;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        input  HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        output HREADY, HRESP
    );

endinterface

// File: rtl/seg_rr_arb2.sv
// rtl/seg_rr_arb2.sv - two-way round-robin arbiter, purely combinational
module seg_rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic gnt0,
    output logic gnt1,
    output logic winner
);

    // A lone requester always wins; on contention the one not served last time wins.
    always_comb begin
        gnt0   = valid0 && (!valid1 || last_grant);
        gnt1   = valid1 && (!valid0 || !last_grant);
        winner = gnt1;
    end

endmodule

// File: rtl/seg_disp_sched.sv
// rtl/seg_disp_sched.sv - AHB-Lite master writing arbitrated frames to the seg7x8 display; optional SEG_DISP_SCHED_SKIP_DUP_EN
module seg_disp_sched
    import seg_disp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             req0_valid,
    input  logic [31:0]      req0_data,
    input  logic [7:0]       req0_dp,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_data,
    input  logic [7:0]       req1_dp,
    output logic             req1_ready,
    seg_disp_sched_if.master ahb,
    output logic             busy,
    output logic             grant_id,
    output logic             err_pulse
);

    state_t      state;
    state_t      state_nx;
    logic        gnt0;
    logic        gnt1;
    logic        win_id;
    logic        last_grant;
    logic [31:0] hold_data;
    logic [7:0]  hold_dp;
    logic [31:0] sel_data;
    logic [7:0]  sel_dp;
    logic        accept;
    logic        skip;
    logic        dphase;
    logic        err_now;

    seg_rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .winner     (win_id)
    );

    assign sel_data    = win_id ? req1_data : req0_data;
    assign sel_dp      = win_id ? req1_dp : req0_dp;
    assign accept      = (state == ST_IDLE) && (gnt0 || gnt1);
    assign req0_ready  = (state == ST_IDLE) && gnt0;
    assign req1_ready  = (state == ST_IDLE) && gnt1;
    assign busy        = (state != ST_IDLE);
    assign err_now     = dphase && ahb.HREADY && ahb.HRESP;
    assign ahb.HSIZE   = HSIZE_WORD;

`ifdef SEG_DISP_SCHED_SKIP_DUP_EN
    logic [39:0] shadow;
    logic        shadow_valid;
    logic        frame_err;

    // A frame identical to the last cleanly written one is acknowledged without bus traffic.
    assign skip = shadow_valid && !err_now && ({sel_data, sel_dp} == shadow);

    // Shadow of the last frame whose both writes completed without an error response.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            shadow       <= '0;
            shadow_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            if (accept) begin
                frame_err <= 1'b0;
            end else if (err_now) begin
                frame_err <= 1'b1;
            end
            if (state == ST_D1 && ahb.HREADY) begin
                shadow       <= {hold_data, hold_dp};
                shadow_valid <= !frame_err && !err_now;
            end else if (err_now) begin
                shadow_valid <= 1'b0;
            end
        end
    end
`else
    assign skip = 1'b0;
`endif

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: acceptance leaves IDLE, the bus states advance only on HREADY
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept && !skip) state_nx = ST_A0;
            ST_A0:   if (ahb.HREADY) state_nx = ST_A1D0;
            ST_A1D0: if (ahb.HREADY) state_nx = ST_D1;
            ST_D1:   if (ahb.HREADY) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Capture the winning frame and remember who was served
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_data  <= '0;
            hold_dp    <= '0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
        end else if (accept) begin
            hold_data  <= sel_data;
            hold_dp    <= sel_dp;
            last_grant <= win_id;
            grant_id   <= win_id;
        end
    end

    // Registered AHB outputs: the bus shows the current state's phase one cycle later, frozen while HREADY is low
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ahb.HTRANS <= HTRANS_IDLE;
            ahb.HADDR  <= BASE_ADDR;
            ahb.HWRITE <= 1'b0;
            ahb.HWDATA <= '0;
        end else if (ahb.HREADY) begin
            case (state)
                ST_IDLE: begin
                    ahb.HTRANS <= HTRANS_IDLE;
                end
                ST_A0: begin
                    ahb.HTRANS <= HTRANS_NONSEQ;
                    ahb.HWRITE <= 1'b1;
                    ahb.HADDR  <= BASE_ADDR + WORD0_OFS;
                end
                ST_A1D0: begin
                    ahb.HTRANS <= HTRANS_NONSEQ;
                    ahb.HADDR  <= BASE_ADDR + WORD1_OFS;
                    ahb.HWDATA <= pack_word(hold_data[15:0], hold_dp[3:0]);
                end
                ST_D1: begin
                    ahb.HTRANS <= HTRANS_IDLE;
                    ahb.HWRITE <= 1'b0;
                    ahb.HWDATA <= pack_word(hold_data[31:16], hold_dp[7:4]);
                end
                default: ahb.HTRANS <= HTRANS_IDLE;
            endcase
        end
    end

    // Track whether a data phase is in progress and flag error responses on it
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dphase    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= err_now;
            if (ahb.HREADY) begin
                dphase <= (ahb.HTRANS == HTRANS_NONSEQ);
            end
        end
    end

endmodule

// File: tb/tb_seg_disp_sched.sv
// tb/tb_seg_disp_sched.sv - scoreboard bench for seg_disp_sched
module tb_seg_disp_sched;

    localparam logic [31:0] BASE = 32'h4000_0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0v, r1v, r0r, r1r;
    logic [31:0] r0d, r1d;
    logic [7:0]  r0p, r1p;
    logic        busy, gid, errp;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_writes = 0;
    int nonseq_cnt = 0;
    int err_cnt = 0;
    int busy_cnt = 0;
    int last_write_cyc = 0;
    int accept_cyc = 0;

    logic [63:0] sb[$];
    logic        dp_pend = 1'b0;
    logic [31:0] dp_addr;
    logic        sh_v = 1'b0;
    logic [39:0] sh_val;

    seg_disp_sched_if bus();

    seg_disp_sched #(.BASE_ADDR(BASE)) dut (
        .HCLK       (clk),
        .HRESETn    (rst_n),
        .req0_valid (r0v),
        .req0_data  (r0d),
        .req0_dp    (r0p),
        .req0_ready (r0r),
        .req1_valid (r1v),
        .req1_data  (r1d),
        .req1_dp    (r1p),
        .req1_ready (r1r),
        .ahb        (bus),
        .busy       (busy),
        .grant_id   (gid),
        .err_pulse  (errp)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1);
    end

    function automatic logic [31:0] exp_word(input logic [31:0] d, input logic [7:0] p, input int w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = {3'b000, p[4*w + k], d[16*w + 4*k +: 4]};
        end
        return r;
    endfunction

    // Model of the accept decision: push the two expected writes unless the frame is a duplicate.
    task automatic model_push(input logic [31:0] d, input logic [7:0] p);
        logic dup;
        dup = 1'b0;
`ifdef SEG_DISP_SCHED_SKIP_DUP_EN
        dup = sh_v && (sh_val == {d, p});
`endif
        if (!dup) begin
            sb.push_back({BASE, exp_word(d, p, 0)});
            sb.push_back({BASE + 32'h4, exp_word(d, p, 1)});
            sh_v = 1'b1;
            sh_val = {d, p};
        end
    endtask

    // Bus monitor: every completed data phase is compared with the scoreboard head.
    initial forever begin
        logic [63:0] exp;
        @(negedge clk);
        if (!rst_n) begin
            dp_pend = 1'b0;
        end else begin
            if (errp) err_cnt++;
            if (busy) busy_cnt++;
            if (dp_pend && bus.HREADY) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_write: got addr %h data %h, required no write", dp_addr, bus.HWDATA);
                end else begin
                    exp = sb.pop_front();
                    if ({dp_addr, bus.HWDATA} !== exp) begin
                        n_fail++;
                        $display("FAIL sb_write: got addr %h data %h, required addr %h data %h",
                                 dp_addr, bus.HWDATA, exp[63:32], exp[31:0]);
                    end
                end
                n_writes++;
                last_write_cyc = cyc;
                dp_pend = 1'b0;
            end
            if (bus.HREADY && bus.HTRANS == 2'b10) begin
                nonseq_cnt++;
                dp_pend = 1'b1;
                dp_addr = bus.HADDR;
            end
        end
    end

    task automatic accept_frame(input bit id, input logic [31:0] d, input logic [7:0] p, output bit ok);
        ok = 1'b0;
        if (id == 1'b0) begin r0v = 1'b1; r0d = d; r0p = p; end
        else            begin r1v = 1'b1; r1d = d; r1p = p; end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if ((id == 1'b0) ? r0r : r1r) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout: got ready=0 for req%0d, required ready=1", id);
        end else begin
            accept_cyc = cyc;
            model_push(d, p);
        end
        @(posedge clk);
        #1;
        r0v = 1'b0;
        r1v = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while ((sb.size() != 0 || busy || dp_pend) && i < 40) begin
            @(negedge clk);
            i++;
        end
        n_checks++;
        if (i >= 40) begin
            n_fail++;
            $display("FAIL %s_idle_timeout: got %0d pending writes, required 0", tag, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic find_word1_addr(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk);
            #1;
            if (bus.HTRANS == 2'b10 && bus.HADDR == BASE + 32'h4) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s_find_word1: got no address phase at %h, required one", tag, BASE + 32'h4);
        end
    endtask

    task automatic test_reset();
        r0v = 0; r1v = 0; r0d = 0; r1d = 0; r0p = 0; r1p = 0;
        bus.HREADY = 1'b1;
        bus.HRESP = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.HTRANS !== 2'b00) begin n_fail++; $display("FAIL reset_htrans: got %h, required 0", bus.HTRANS); end
        n_checks++; if (bus.HADDR !== BASE) begin n_fail++; $display("FAIL reset_haddr: got %h, required %h", bus.HADDR, BASE); end
        n_checks++; if (bus.HWRITE !== 1'b0) begin n_fail++; $display("FAIL reset_hwrite: got %b, required 0", bus.HWRITE); end
        n_checks++; if (bus.HSIZE !== 3'b010) begin n_fail++; $display("FAIL reset_hsize: got %b, required 010", bus.HSIZE); end
        n_checks++; if (bus.HWDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hwdata: got %h, required 0", bus.HWDATA); end
        n_checks++; if ({busy, gid, errp} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got busy/gid/err %b, required 000", {busy, gid, errp}); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (bus.HTRANS !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_after_release: got htrans %h busy %b, required 0 0", bus.HTRANS, busy); end
    endtask

    task automatic test_single();
        bit ok;
        int w0, b0;
        w0 = n_writes;
        b0 = busy_cnt;
        ok = 1'b0;
        r0v = 1'b1; r0d = 32'h89AB_CDEF; r0p = 8'h01;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (r0r) ok = 1'b1;
        end
        n_checks++; if (!ok || r1r) begin n_fail++; $display("FAIL single_ready: got r0r %b r1r %b, required 1 0", r0r, r1r); end
        accept_cyc = cyc;
        sb.push_back({BASE, 32'h0C0D_0E1F});
        sb.push_back({BASE + 32'h4, 32'h0809_0A0B});
        sh_v = 1'b1;
        sh_val = {32'h89AB_CDEF, 8'h01};
        @(posedge clk);
        #1;
        r0v = 1'b0;
        n_checks++; if (bus.HTRANS !== 2'b00 || busy !== 1'b1 || gid !== 1'b0) begin n_fail++; $display("FAIL single_a0: got htrans %h busy %b gid %b, required 0 1 0", bus.HTRANS, busy, gid); end
        @(posedge clk);
        #1;
        n_checks++; if ({bus.HTRANS, bus.HADDR, bus.HWRITE} !== {2'b10, BASE, 1'b1}) begin n_fail++; $display("FAIL single_addr0: got %h %h %b, required 2 %h 1", bus.HTRANS, bus.HADDR, bus.HWRITE, BASE); end
        @(posedge clk);
        #1;
        n_checks++; if ({bus.HTRANS, bus.HADDR, bus.HWDATA} !== {2'b10, BASE + 32'h4, 32'h0C0D_0E1F}) begin n_fail++; $display("FAIL single_addr1: got %h %h %h, required 2 %h 0c0d0e1f", bus.HTRANS, bus.HADDR, bus.HWDATA, BASE + 32'h4); end
        @(posedge clk);
        #1;
        n_checks++; if ({bus.HTRANS, bus.HWRITE, bus.HWDATA} !== {2'b00, 1'b0, 32'h0809_0A0B}) begin n_fail++; $display("FAIL single_data1: got %h %b %h, required 0 0 08090a0b", bus.HTRANS, bus.HWRITE, bus.HWDATA); end
        wait_idle("single");
        n_checks++; if (n_writes - w0 !== 2) begin n_fail++; $display("FAIL single_writes: got %0d, required 2", n_writes - w0); end
        n_checks++; if (last_write_cyc - accept_cyc !== 4) begin n_fail++; $display("FAIL single_latency: got %0d, required 4", last_write_cyc - accept_cyc); end
        n_checks++; if (busy_cnt - b0 !== 3) begin n_fail++; $display("FAIL single_busy_cycles: got %0d, required 3", busy_cnt - b0); end
    endtask

    task automatic test_back_to_back();
        int grants[4];
        int gcyc[4];
        int n;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        sh_v = 1'b0;
        r0v = 1'b1; r0d = 32'h1234_5678; r0p = 8'h3C;
        r1v = 1'b1; r1d = 32'hFEDC_BA98; r1p = 8'hC3;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (r0r && r1r) begin
                n_checks++; n_fail++;
                $display("FAIL b2b_both_ready: got both ready, required at most one");
            end
            if (r0r || r1r) begin
                grants[n] = r1r ? 1 : 0;
                gcyc[n] = cyc;
                if (r1r) model_push(r1d, r1p);
                else     model_push(r0d, r0p);
                n++;
            end
        end
        @(posedge clk);
        #1;
        r0v = 1'b0;
        r1v = 1'b0;
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL b2b_grant_count: got %0d, required 4", n); end
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (grants[i] !== i % 2) begin n_fail++; $display("FAIL b2b_grant_%0d: got %0d, required %0d", i, grants[i], i % 2); end
        end
        for (int i = 1; i < n; i++) begin
            n_checks++;
            if (gcyc[i] - gcyc[i-1] !== 4) begin n_fail++; $display("FAIL b2b_spacing_%0d: got %0d, required 4", i, gcyc[i] - gcyc[i-1]); end
        end
        wait_idle("b2b");
    endtask

    task automatic test_stall();
        bit ok;
        logic [31:0] w0;
        w0 = exp_word(32'h0F1E_2D3C, 8'hA5, 0);
        accept_frame(1'b1, 32'h0F1E_2D3C, 8'hA5, ok);
        find_word1_addr("stall");
        bus.HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({bus.HTRANS, bus.HADDR, bus.HWDATA} !== {2'b10, BASE + 32'h4, w0}) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got %h %h %h, required 2 %h %h", i, bus.HTRANS, bus.HADDR, bus.HWDATA, BASE + 32'h4, w0);
            end
            if (i == 2) bus.HREADY = 1'b1;
        end
        wait_idle("stall");
        n_checks++; if (last_write_cyc - accept_cyc !== 7) begin n_fail++; $display("FAIL stall_latency: got %0d, required 7", last_write_cyc - accept_cyc); end
    endtask

    task automatic test_error();
        bit ok;
        int e0, w0;
        e0 = err_cnt;
        w0 = n_writes;
        accept_frame(1'b0, 32'h0000_1111, 8'h10, ok);
        find_word1_addr("error");
        bus.HREADY = 1'b0;
        bus.HRESP = 1'b1;
        @(posedge clk);
        #1;
        bus.HREADY = 1'b1;
        @(posedge clk);
        #1;
        bus.HRESP = 1'b0;
        sh_v = 1'b0;
        wait_idle("error");
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL error_pulse_cycles: got %0d, required 1", err_cnt - e0); end
        n_checks++; if (n_writes - w0 !== 2) begin n_fail++; $display("FAIL error_writes: got %0d, required 2", n_writes - w0); end
        n_checks++; if (busy !== 1'b0 || bus.HTRANS !== 2'b00) begin n_fail++; $display("FAIL error_return_idle: got busy %b htrans %h, required 0 0", busy, bus.HTRANS); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        accept_frame(1'b0, 32'h5555_AAAA, 8'h0F, ok);
        find_word1_addr("rstmid");
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.HTRANS !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got htrans %h busy %b, required 0 0", bus.HTRANS, busy); end
        n_checks++; if (bus.HADDR !== BASE || bus.HWDATA !== 32'h0) begin n_fail++; $display("FAIL rstmid_bus: got %h %h, required %h 0", bus.HADDR, bus.HWDATA, BASE); end
        sb.delete();
        sh_v = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        r0v = 1'b1; r0d = 32'h2468_ACE0; r0p = 8'h55;
        r1v = 1'b1; r1d = 32'h1357_9BDF; r1p = 8'hAA;
        @(negedge clk);
        n_checks++; if ({r0r, r1r} !== 2'b10) begin n_fail++; $display("FAIL rstmid_priority: got r0r/r1r %b, required 10", {r0r, r1r}); end
        if (r0r) model_push(r0d, r0p);
        @(posedge clk);
        #1;
        r0v = 1'b0;
        r1v = 1'b0;
        n_checks++; if (gid !== 1'b0) begin n_fail++; $display("FAIL rstmid_grant_id: got %b, required 0", gid); end
        wait_idle("rstmid");
    endtask

    task automatic test_dup_frames();
        bit ok;
        int w0, ns0, b0;
        accept_frame(1'b1, 32'hC0FF_EE00, 8'h81, ok);
        wait_idle("dup_first");
        w0 = n_writes;
        ns0 = nonseq_cnt;
        b0 = busy_cnt;
        accept_frame(1'b1, 32'hC0FF_EE00, 8'h81, ok);
        repeat (8) @(posedge clk);
        #1;
        wait_idle("dup_second");
`ifdef SEG_DISP_SCHED_SKIP_DUP_EN
        n_checks++; if (nonseq_cnt - ns0 !== 0 || n_writes - w0 !== 0) begin n_fail++; $display("FAIL dup_skipped: got %0d transfers %0d writes, required 0 0", nonseq_cnt - ns0, n_writes - w0); end
        n_checks++; if (busy_cnt - b0 !== 0) begin n_fail++; $display("FAIL dup_busy: got %0d busy cycles, required 0", busy_cnt - b0); end
        w0 = n_writes;
        accept_frame(1'b1, 32'hC0FF_EE01, 8'h81, ok);
        wait_idle("dup_changed");
        n_checks++; if (n_writes - w0 !== 2) begin n_fail++; $display("FAIL dup_changed_writes: got %0d, required 2", n_writes - w0); end
`else
        n_checks++; if (nonseq_cnt - ns0 !== 2 || n_writes - w0 !== 2) begin n_fail++; $display("FAIL dup_written: got %0d transfers %0d writes, required 2 2", nonseq_cnt - ns0, n_writes - w0); end
        n_checks++; if (busy_cnt - b0 !== 3) begin n_fail++; $display("FAIL dup_busy: got %0d busy cycles, required 3", busy_cnt - b0); end
`endif
    endtask

    initial begin
        bus.HREADY = 1'b1;
        bus.HRESP = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_error();
        test_reset_mid();
        test_dup_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
